// File: rtl/fir_coef_pkg.sv
// Shared types, default coefficient tables and helpers for the FIR coefficient bank.
// Build option: define COEF_SYM_EN for half-depth symmetric storage in fir_coef_bank.
package fir_coef_pkg;

   typedef enum logic {IDLE, STREAM} seq_state_t;

   localparam int DEF_BANKS = 2;
   localparam int DEF_TAPS  = 32;

   // Bank 0: antisymmetric high-pass set. Bank 1: symmetric low-pass alternate set.
   localparam logic [15:0] DEFAULT_COEF [DEF_BANKS][DEF_TAPS] = '{
      '{16'hFFF5, 16'h0011, 16'hFFE3, 16'h0030, 16'hFFB2, 16'h0078, 16'hFF4C, 16'h0104,
        16'hFE9A, 16'h0201, 16'hFD0E, 16'h0455, 16'hF9E2, 16'h0A3B, 16'hEE60, 16'h4E86,
        16'hB17A, 16'h11A0, 16'hF5C5, 16'h061E, 16'hFBAB, 16'h02F2, 16'hFDFF, 16'h0166,
        16'hFEFC, 16'h00B4, 16'hFF88, 16'h004E, 16'hFFD0, 16'h001D, 16'hFFEF, 16'h000B},
      '{16'h0008, 16'h0012, 16'h0020, 16'h0035, 16'h0052, 16'h0078, 16'h00A8, 16'h00E2,
        16'h0126, 16'h0174, 16'h01CA, 16'h0228, 16'h028A, 16'h02EE, 16'h034F, 16'h03A8,
        16'h03A8, 16'h034F, 16'h02EE, 16'h028A, 16'h0228, 16'h01CA, 16'h0174, 16'h0126,
        16'h00E2, 16'h00A8, 16'h0078, 16'h0052, 16'h0035, 16'h0020, 16'h0012, 16'h0008}
   };

   // Out-of-range bank requests fall back to bank 0.
   function automatic int unsigned clamp_bank(input int unsigned sel, input int unsigned nbank);
      return (sel < nbank) ? sel : 0;
   endfunction

endpackage

// File: rtl/fir_coef_bank_if.sv
// Read-stream and write-port signals of the FIR coefficient bank.
// master = MAC / host side, slave = coefficient bank.
interface fir_coef_bank_if #(
   parameter int COEF_W = 16,
   parameter int TAPS   = 32,
   parameter int NBANK  = 2
);
   localparam int AW = $clog2(TAPS);
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

   logic              rd_start;
   logic [BW-1:0]     bank_sel;
   logic              rd_valid;
   logic              rd_ready;
   logic [AW-1:0]     rd_addr;
   logic [COEF_W-1:0] rd_data;
   logic              rd_last;
   logic              busy;
   logic [BW-1:0]     active_bank;
   logic              wr_valid;
   logic              wr_ready;
   logic [BW-1:0]     wr_bank;
   logic [AW-1:0]     wr_addr;
   logic [COEF_W-1:0] wr_data;

   modport master (
      output rd_start, bank_sel, rd_ready, wr_valid, wr_bank, wr_addr, wr_data,
      input  rd_valid, rd_addr, rd_data, rd_last, busy, active_bank, wr_ready
   );

   modport slave (
      input  rd_start, bank_sel, rd_ready, wr_valid, wr_bank, wr_addr, wr_data,
      output rd_valid, rd_addr, rd_data, rd_last, busy, active_bank, wr_ready
   );
endinterface

// File: rtl/fir_coef_seq.sv
// Stream sequencer: IDLE/STREAM FSM, tap counter and valid/ready handshake.
// Emits the tap index and latched bank used to address coefficient storage.
module fir_coef_seq
   import fir_coef_pkg::*;
#(
   parameter int TAPS  = 32,
   parameter int NBANK = 2,
   parameter int AW    = $clog2(TAPS),
   parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_start,
   input  logic [BW-1:0] bank_sel,
   input  logic          rd_ready,
   output logic          rd_valid,
   output logic [AW-1:0] rd_addr,
   output logic          rd_last,
   output logic          busy,
   output logic [BW-1:0] active_bank
);

   seq_state_t    state_q, state_d;
   logic [AW-1:0] counter_q, counter_d;
   logic [BW-1:0] bank_q, bank_d;
   logic          at_last;
   logic [BW-1:0] sel_clamped;

   assign at_last     = (counter_q == AW'(TAPS - 1));
   assign sel_clamped = BW'(clamp_bank(32'(bank_sel), NBANK));

   // State, tap counter and latched bank registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         counter_q <= '0;
         bank_q    <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         bank_q    <= bank_d;
      end
   end

   // Next-state: advance only on accepted beats; a start on the last beat chains streams.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      bank_d    = bank_q;
      case (state_q)
         IDLE: begin
            if (rd_start) begin
               state_d   = STREAM;
               counter_d = '0;
               bank_d    = sel_clamped;
            end
         end
         STREAM: begin
            if (rd_ready) begin
               if (at_last) begin
                  counter_d = '0;
                  if (rd_start) begin
                     bank_d = sel_clamped;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  counter_d = counter_q + AW'(1);
               end
            end
         end
         default: begin
            state_d   = IDLE;
            counter_d = '0;
         end
      endcase
   end

   assign rd_valid    = (state_q == STREAM);
   assign busy        = (state_q == STREAM);
   assign rd_addr     = counter_q;
   assign rd_last     = (state_q == STREAM) && at_last;
   assign active_bank = bank_q;

endmodule

// File: rtl/fir_coef_bank.sv
// Writable multi-bank FIR coefficient store with a streaming read sequencer.
// Build option: COEF_SYM_EN stores only TAPS/2 entries per bank and mirrors the upper taps.
module fir_coef_bank
   import fir_coef_pkg::*;
#(
   parameter int COEF_W = 16,
   parameter int TAPS   = 32,
   parameter int NBANK  = 2
) (
   input logic            clk,
   input logic            rst,
   fir_coef_bank_if.slave bus
);

   localparam int AW = $clog2(TAPS);
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
`ifdef COEF_SYM_EN
   localparam int DEPTH = TAPS / 2;
`else
   localparam int DEPTH = TAPS;
`endif
   localparam int SW = $clog2(DEPTH);

   logic [COEF_W-1:0] mem [NBANK][DEPTH];
   logic              rd_valid;
   logic              busy;
   logic [AW-1:0]     rd_tap;
   logic [BW-1:0]     rd_bank;
   logic [AW-1:0]     rd_entry;
   logic              wr_ready;
   logic              wr_fire;

   fir_coef_seq #(
      .TAPS (TAPS),
      .NBANK(NBANK),
      .AW   (AW),
      .BW   (BW)
   ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .rd_start   (bus.rd_start),
      .bank_sel   (bus.bank_sel),
      .rd_ready   (bus.rd_ready),
      .rd_valid   (rd_valid),
      .rd_addr    (rd_tap),
      .rd_last    (bus.rd_last),
      .busy       (busy),
      .active_bank(rd_bank)
   );

   // Map a stream tap onto a storage entry (mirrored upper half when symmetric).
   always_comb begin
      rd_entry = rd_tap;
`ifdef COEF_SYM_EN
      if (rd_tap >= AW'(TAPS / 2)) begin
         rd_entry = AW'(TAPS - 1) - rd_tap;
      end
`endif
   end

   // Writes into the bank being streamed stall; out-of-range targets are accepted and dropped.
   always_comb begin
      wr_ready = !(busy && (bus.wr_bank == rd_bank));
      wr_fire  = bus.wr_valid && wr_ready && (32'(bus.wr_bank) < NBANK);
`ifdef COEF_SYM_EN
      wr_fire  = wr_fire && (bus.wr_addr < AW'(TAPS / 2));
`endif
   end

   // Coefficient storage: reset loads the default tables, otherwise accept writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NBANK; b++) begin
            for (int t = 0; t < DEPTH; t++) begin
               mem[b][t] <= COEF_W'($signed(DEFAULT_COEF[b % DEF_BANKS][t % DEF_TAPS]));
            end
         end
      end else if (wr_fire) begin
         mem[bus.wr_bank][bus.wr_addr[SW-1:0]] <= bus.wr_data;
      end
   end

   assign bus.rd_valid    = rd_valid;
   assign bus.busy        = busy;
   assign bus.rd_addr     = rd_tap;
   assign bus.active_bank = rd_bank;
   assign bus.wr_ready    = wr_ready;
   assign bus.rd_data     = rd_valid ? mem[rd_bank][rd_entry[SW-1:0]] : '0;

endmodule
